// File: rtl/cva6_store_unit_model_if.sv
// Store-unit model bus: issue, commit and memory handshake plus queue status.
interface cva6_store_unit_model_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] instr_i;
    logic              instr_valid_i;
    logic              store_mem_resp_i;
    logic              commit_i;
    logic              ready_o;
    logic              commit_ready_o;
    logic              result_valid_o;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [2:0]        spec_count_o;
    logic [2:0]        commit_count_o;
    logic              store_buffer_empty_o;
    logic              no_st_pending_o;
    logic              err_o;

    modport master (
        output instr_i, instr_valid_i, store_mem_resp_i, commit_i,
        input  ready_o, commit_ready_o, result_valid_o, mem_req_o, mem_addr_o,
               spec_count_o, commit_count_o, store_buffer_empty_o, no_st_pending_o, err_o
    );

    modport slave (
        input  instr_i, instr_valid_i, store_mem_resp_i, commit_i,
        output ready_o, commit_ready_o, result_valid_o, mem_req_o, mem_addr_o,
               spec_count_o, commit_count_o, store_buffer_empty_o, no_st_pending_o, err_o
    );
endinterface

// File: rtl/cva6_store_unit_model.sv
// Lock-step reference model of the CVA6 store unit: speculative queue feeding a
// committed queue that drains to memory, with a sticky protocol-error flag.
module cva6_store_unit_model #(
    parameter int DEPTH_SPEC   = 4,
    parameter int DEPTH_COMMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    cva6_store_unit_model_if.slave    bus
);
    localparam int SPW = $clog2(DEPTH_SPEC);
    localparam int CPW = $clog2(DEPTH_COMMIT);
    localparam int SCW = SPW + 1;
    localparam int CCW = CPW + 1;
    localparam logic [SCW-1:0] SFULL = SCW'(DEPTH_SPEC);
    localparam logic [CCW-1:0] CFULL = CCW'(DEPTH_COMMIT);

    logic [ADDR_W-1:0] r_spec_q [DEPTH_SPEC];
    logic [ADDR_W-1:0] r_cmt_q  [DEPTH_COMMIT];
    logic [SPW-1:0]    r_spec_wr, r_spec_rd;
    logic [CPW-1:0]    r_cmt_wr,  r_cmt_rd;
    logic [SCW-1:0]    r_spec_cnt;
    logic [CCW-1:0]    r_cmt_cnt;
    logic              r_result_valid;
    logic              r_err;

    logic w_ready, w_commit_ready, w_push, w_commit, w_pop, w_err;

    // All three events are judged on pre-edge occupancy, so a full queue
    // refuses a push even when it is also being drained this cycle.
    always_comb begin
        w_ready        = (r_spec_cnt != SFULL);
        w_commit_ready = (r_cmt_cnt != CFULL);
        w_push         = bus.instr_valid_i && w_ready;
        w_commit       = bus.commit_i && (r_spec_cnt != '0) && w_commit_ready;
        w_pop          = bus.store_mem_resp_i && (r_cmt_cnt != '0);
        w_err          = (bus.instr_valid_i && !w_ready) || (bus.commit_i && !w_commit);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_spec_wr      <= '0;
            r_spec_rd      <= '0;
            r_cmt_wr       <= '0;
            r_cmt_rd       <= '0;
            r_spec_cnt     <= '0;
            r_cmt_cnt      <= '0;
            r_result_valid <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            if (w_push)   r_spec_wr <= r_spec_wr + 1'b1;
            if (w_commit) r_spec_rd <= r_spec_rd + 1'b1;
            if (w_commit) r_cmt_wr  <= r_cmt_wr + 1'b1;
            if (w_pop)    r_cmt_rd  <= r_cmt_rd + 1'b1;
            r_spec_cnt     <= r_spec_cnt + SCW'(w_push) - SCW'(w_commit);
            r_cmt_cnt      <= r_cmt_cnt + CCW'(w_commit) - CCW'(w_pop);
            r_result_valid <= w_push;
            r_err          <= r_err | w_err;
        end
    end

    // Payload storage needs no reset: occupancy counts gate every read.
    always_ff @(posedge clk_i) begin
        if (w_push)   r_spec_q[r_spec_wr] <= bus.instr_i;
        if (w_commit) r_cmt_q[r_cmt_wr]   <= r_spec_q[r_spec_rd];
    end

    always_comb begin
        bus.ready_o              = w_ready;
        bus.commit_ready_o       = w_commit_ready;
        bus.result_valid_o       = r_result_valid;
        bus.mem_req_o            = (r_cmt_cnt != '0);
        bus.mem_addr_o           = (r_cmt_cnt != '0) ? r_cmt_q[r_cmt_rd] : '0;
        bus.spec_count_o         = 3'(r_spec_cnt);
        bus.commit_count_o       = 3'(r_cmt_cnt);
        bus.store_buffer_empty_o = (r_spec_cnt == '0) && (r_cmt_cnt == '0);
        bus.no_st_pending_o      = (r_cmt_cnt == '0);
        bus.err_o                = r_err;
    end
endmodule

// File: tb/tb_cva6_store_unit_model.sv
// Directed bench for cva6_store_unit_model: vector table plus hand-written corner sequences.
module tb_cva6_store_unit_model;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    cva6_store_unit_model_if #(.ADDR_W(32)) bus ();

    cva6_store_unit_model #(.DEPTH_SPEC(4), .DEPTH_COMMIT(4), .ADDR_W(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic        rst_n, vld;
        logic [31:0] addr;
        logic        cm, rsp;
        logic        rdy, crdy, rv, mreq;
        logic [31:0] maddr;
        logic [2:0]  sc, cc;
        logic        emp, nop, err;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic rdy, crdy, rv, mreq,
                               input logic [31:0] maddr, input logic [2:0] sc, cc,
                               input logic emp, nop, err);
        chk({tag, ".ready"},        32'(bus.ready_o),              32'(rdy));
        chk({tag, ".commit_ready"}, 32'(bus.commit_ready_o),       32'(crdy));
        chk({tag, ".result_valid"}, 32'(bus.result_valid_o),       32'(rv));
        chk({tag, ".mem_req"},      32'(bus.mem_req_o),            32'(mreq));
        chk({tag, ".mem_addr"},     bus.mem_addr_o,                maddr);
        chk({tag, ".spec_count"},   32'(bus.spec_count_o),         32'(sc));
        chk({tag, ".commit_count"}, 32'(bus.commit_count_o),       32'(cc));
        chk({tag, ".sb_empty"},     32'(bus.store_buffer_empty_o), 32'(emp));
        chk({tag, ".no_st_pend"},   32'(bus.no_st_pending_o),      32'(nop));
        chk({tag, ".err"},          32'(bus.err_o),                32'(err));
    endtask

    task automatic cyc(input logic r, v, input logic [31:0] a, input logic c, s);
        @(negedge clk);
        rst_n                = r;
        bus.instr_valid_i    = v;
        bus.instr_i          = a;
        bus.commit_i         = c;
        bus.store_mem_resp_i = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n                = 1'b0;
        bus.instr_valid_i    = 1'b0;
        bus.instr_i          = '0;
        bus.commit_i         = 1'b0;
        bus.store_mem_resp_i = 1'b0;

        //          rst vld addr          cm rsp  rdy crdy rv mreq maddr         sc cc emp nop err
        vecs[0]  = '{0, 0, 32'h0,         0, 0,   1, 1, 0, 0, 32'h0,         0, 0, 1, 1, 0};
        vecs[1]  = '{1, 0, 32'h0,         0, 0,   1, 1, 0, 0, 32'h0,         0, 0, 1, 1, 0};
        vecs[2]  = '{1, 0, 32'h0,         0, 0,   1, 1, 0, 0, 32'h0,         0, 0, 1, 1, 0};
        vecs[3]  = '{1, 0, 32'h0,         0, 0,   1, 1, 0, 0, 32'h0,         0, 0, 1, 1, 0};
        vecs[4]  = '{1, 1, 32'h1234_5678, 0, 0,   1, 1, 1, 0, 32'h0,         1, 0, 0, 1, 0};
        vecs[5]  = '{1, 0, 32'h0,         1, 0,   1, 1, 0, 1, 32'h1234_5678, 0, 1, 0, 0, 0};
        vecs[6]  = '{1, 0, 32'h0,         0, 1,   1, 1, 0, 0, 32'h0,         0, 0, 1, 1, 0};
        vecs[7]  = '{1, 1, 32'h100,       0, 0,   1, 1, 1, 0, 32'h0,         1, 0, 0, 1, 0};
        vecs[8]  = '{1, 1, 32'h104,       0, 0,   1, 1, 1, 0, 32'h0,         2, 0, 0, 1, 0};
        vecs[9]  = '{1, 1, 32'h108,       0, 0,   1, 1, 1, 0, 32'h0,         3, 0, 0, 1, 0};
        vecs[10] = '{1, 1, 32'h10C,       0, 0,   0, 1, 1, 0, 32'h0,         4, 0, 0, 1, 0};
        vecs[11] = '{1, 1, 32'h110,       0, 0,   0, 1, 0, 0, 32'h0,         4, 0, 0, 1, 1};
        vecs[12] = '{1, 0, 32'h0,         0, 0,   0, 1, 0, 0, 32'h0,         4, 0, 0, 1, 1};
        vecs[13] = '{0, 0, 32'h0,         0, 0,   1, 1, 0, 0, 32'h0,         0, 0, 1, 1, 0};
        vecs[14] = '{1, 0, 32'h0,         1, 0,   1, 1, 0, 0, 32'h0,         0, 0, 1, 1, 1};
        vecs[15] = '{0, 0, 32'h0,         0, 0,   1, 1, 0, 0, 32'h0,         0, 0, 1, 1, 0};
        vecs[16] = '{1, 0, 32'h0,         0, 1,   1, 1, 0, 0, 32'h0,         0, 0, 1, 1, 0};
        vecs[17] = '{1, 0, 32'h0,         0, 0,   1, 1, 0, 0, 32'h0,         0, 0, 1, 1, 0};

        for (int i = 0; i < 18; i++) begin
            cyc(vecs[i].rst_n, vecs[i].vld, vecs[i].addr, vecs[i].cm, vecs[i].rsp);
            check_state($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].crdy, vecs[i].rv,
                        vecs[i].mreq, vecs[i].maddr, vecs[i].sc, vecs[i].cc,
                        vecs[i].emp, vecs[i].nop, vecs[i].err);
        end

        // Commit and memory pop in the same cycle: committed head is replaced.
        cyc(1, 1, 32'hA0, 0, 0);
        check_state("s5.pushA", 1, 1, 1, 0, 32'h0, 1, 0, 0, 1, 0);
        cyc(1, 0, 32'h0, 1, 0);
        check_state("s5.cmA", 1, 1, 0, 1, 32'hA0, 0, 1, 0, 0, 0);
        cyc(1, 1, 32'hB0, 0, 0);
        check_state("s5.pushB", 1, 1, 1, 1, 32'hA0, 1, 1, 0, 0, 0);
        cyc(1, 0, 32'h0, 1, 1);
        check_state("s5.cm_rsp", 1, 1, 0, 1, 32'hB0, 0, 1, 0, 0, 0);
        cyc(1, 0, 32'h0, 0, 1);
        check_state("s5.drain", 1, 1, 0, 0, 32'h0, 0, 0, 1, 1, 0);

        // Fill the committed queue, then commit into it while full.
        for (int i = 0; i < 4; i++) cyc(1, 1, 32'hC00 + 32'(i * 4), 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 32'h0, 1, 0);
        check_state("s7.cfull", 1, 0, 0, 1, 32'hC00, 0, 4, 0, 0, 0);
        cyc(1, 1, 32'hD00, 0, 0);
        check_state("s7.push", 1, 0, 1, 1, 32'hC00, 1, 4, 0, 0, 0);
        cyc(1, 0, 32'h0, 1, 0);
        check_state("s7.cm_full", 1, 0, 0, 1, 32'hC00, 1, 4, 0, 0, 1);
        cyc(1, 0, 32'h0, 1, 1);
        check_state("s7.cm_pop_full", 1, 1, 0, 1, 32'hC04, 1, 3, 0, 0, 1);

        // Mid-operation reset with two speculative and two committed entries.
        cyc(0, 0, 32'h0, 0, 0);
        cyc(1, 1, 32'hE0, 0, 0);
        cyc(1, 1, 32'hE4, 0, 0);
        cyc(1, 0, 32'h0, 1, 0);
        cyc(1, 0, 32'h0, 1, 0);
        cyc(1, 1, 32'hE8, 0, 0);
        cyc(1, 1, 32'hEC, 0, 0);
        check_state("s6.pre", 1, 1, 1, 1, 32'hE0, 2, 2, 0, 0, 0);
        cyc(0, 1, 32'hF0, 1, 1);
        check_state("s6.rst", 1, 1, 0, 0, 32'h0, 0, 0, 1, 1, 0);
        cyc(1, 0, 32'h0, 0, 0);
        check_state("s6.post", 1, 1, 0, 0, 32'h0, 0, 0, 1, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
